color_scoreboard: RTL and testbench
===================================

COLOR_SCOREBOARD -- requirements
Module: color_scoreboard

Interface
REQ-001 Parameter NCH, default 4, SHALL set the number of compared channels (1..16).
REQ-002 Parameter LANES, default 32, SHALL set the colored lanes per channel; each lane is 2 bits, so a channel word is 2*LANES bits (64 by default).
REQ-003 Parameter CNTW, default 32, SHALL set the width of every counter output.
REQ-004 Parameter STOP_ON_WRONG, default 0, SHALL, when 1, halt counting on the first wrong or error event.
REQ-005 Port list, clock and reset first:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request.
- stop  in  1  stop request.
- clear  in  1  zero counters and capture.
- valid  in  1  good/bad sample qualifier.
- good  in  NCH*2*LANES  reference colored words; channel c occupies bits [c*2*LANES +: 2*LANES].
- bad  in  NCH*2*LANES  design-under-test colored words, same packing.
- state  out  2  00 IDLE, 01 RUN, 10 HALT.
- cycles  out  CNTW  clocks spent in RUN.
- corrects, wrongs, panics, errors  out  CNTW each  per-channel event counts.
- first_valid  out  1  mismatch captured.
- first_cycle  out  CNTW  cycles value at the captured mismatch.
- first_ch  out  4  channel of the captured mismatch.
- first_lane  out  6  lane of the captured mismatch.

Function
REQ-006 Lane coding SHALL be: 2'b10 logic 0, 2'b11 logic 1, 2'b00/2'b01 uncolored (unknown).
REQ-007 Per channel, each RUN cycle with valid=1 SHALL yield exactly one class, by priority: panic (any good lane uncolored) > error (any bad lane uncolored) > wrong (any lane whose two colored values differ) > correct.
REQ-008 Per sampled cycle, each class counter SHALL increase by the number of channels in that class (0..NCH).
REQ-009 Every counter SHALL saturate at 2^CNTW-1 and never wrap.
REQ-010 Counter updates SHALL be visible one clock after the sampling edge.
REQ-011 Samples with valid=0, or taken in IDLE or HALT, SHALL be ignored.
REQ-012 cycles SHALL increment on every clock in RUN, independent of valid, and saturate.
REQ-013 FSM transitions:
- IDLE -> RUN on start.
- RUN -> IDLE on stop.
- RUN -> HALT on a wrong or error event when STOP_ON_WRONG=1.
- HALT -> IDLE on clear or stop.
- HALT -> RUN on start.
REQ-014 When start and stop are both asserted, stop SHALL win.
REQ-015 The event that triggers HALT SHALL itself be counted; later samples SHALL NOT be counted.
REQ-016 clear SHALL zero all counters and first_* outputs next clock in any state; a valid sample in the same cycle SHALL be discarded; state is unchanged except as in REQ-013.
REQ-017 first_* SHALL capture the first wrong or error event since reset or clear, selecting the lowest-index channel, then its lowest offending lane; first_cycle SHALL be the cycles value before increment.
REQ-018 first_* SHALL hold their values until rst or clear.
REQ-019 If a channel is in the error class, the captured lane SHALL be its lowest uncolored bad lane.

Reset
REQ-020 With rst=1 at a rising edge, state SHALL become IDLE and all counters, first_valid, first_cycle, first_ch and first_lane SHALL become 0.
REQ-021 rst SHALL override start, stop, clear and valid in the same cycle.
REQ-022 rst asserted mid-RUN or in HALT SHALL abort the run with no partial counter update.

Verification
REQ-023 Defaults; start; 10 valid cycles with good==bad==all 2'b10 -> corrects=40, wrongs=panics=errors=0, cycles=10, first_valid=0.
REQ-024 In RUN, channel 2 lane 5 good=2'b11, bad=2'b10 on one valid cycle -> wrongs=1, corrects=3, first_ch=2, first_lane=5, first_valid=1.
REQ-025 STOP_ON_WRONG=1; wrong at cycles=7 -> state=HALT next clock, first_cycle=7, later samples not counted; clear -> IDLE with all outputs 0.
REQ-026 One channel has good lane=2'b00 and bad lane=2'b01 -> panics+1, errors unchanged; another channel has bad lane=2'b00 only -> errors+1.
REQ-027 CNTW=4; 20 all-correct cycles on NCH=4 -> corrects=15 (saturated), no wrap.
REQ-028 start+stop asserted together -> state stays IDLE; rst asserted mid-RUN with valid=1 -> all counters 0 and state=IDLE next clock.

Source files
------------

// File: rtl/color_scoreboard.sv
// Colored-lane scoreboard: classifies each channel's good/bad word pair per sample,
// counts the classes while running, and records the first wrong/error location.
module color_scoreboard #(
  parameter int NCH           = 4,
  parameter int LANES         = 32,
  parameter int CNTW          = 32,
  parameter int STOP_ON_WRONG = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  input  logic                      valid,
  input  logic [NCH*2*LANES-1:0]    good,
  input  logic [NCH*2*LANES-1:0]    bad,
  output logic [1:0]                state,
  output logic [CNTW-1:0]           cycles,
  output logic [CNTW-1:0]           corrects,
  output logic [CNTW-1:0]           wrongs,
  output logic [CNTW-1:0]           panics,
  output logic [CNTW-1:0]           errors,
  output logic                      first_valid,
  output logic [CNTW-1:0]           first_cycle,
  output logic [3:0]                first_ch,
  output logic [5:0]                first_lane
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } state_e;

  state_e          r_state;
  logic [CNTW-1:0] r_cycles, r_corrects, r_wrongs, r_panics, r_errors;
  logic            r_first_valid;
  logic [CNTW-1:0] r_first_cycle;
  logic [3:0]      r_first_ch;
  logic [5:0]      r_first_lane;

  logic [LANES-1:0] w_gu [NCH];
  logic [LANES-1:0] w_bu [NCH];
  logic [LANES-1:0] w_df [NCH];
  logic [NCH-1:0]   w_panic, w_error, w_wrong, w_correct;
  logic [4:0]       w_n_corr, w_n_wrong, w_n_panic, w_n_err;
  logic             w_ev_found;
  logic [3:0]       w_ev_ch;
  logic [5:0]       w_ev_lane;
  logic             w_sample;

  // Upper guard bits catch any carry past CNTW so the result clamps instead of wrapping.
  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input logic [4:0] b);
    logic [CNTW+5:0] s;
    s = {6'b0, a} + {{(CNTW + 1){1'b0}}, b};
    if (s[CNTW+5:CNTW] != 6'b0) return {CNTW{1'b1}};
    return s[CNTW-1:0];
  endfunction

  always_comb begin
    w_panic    = '0;
    w_error    = '0;
    w_wrong    = '0;
    w_correct  = '0;
    w_n_corr   = '0;
    w_n_wrong  = '0;
    w_n_panic  = '0;
    w_n_err    = '0;
    w_ev_found = 1'b0;
    w_ev_ch    = '0;
    w_ev_lane  = '0;
    for (int c = 0; c < NCH; c++) begin
      w_gu[c] = '0;
      w_bu[c] = '0;
      w_df[c] = '0;
      for (int l = 0; l < LANES; l++) begin
        w_gu[c][l] = ~good[(c*LANES+l)*2+1];
        w_bu[c][l] = ~bad[(c*LANES+l)*2+1];
        w_df[c][l] = good[(c*LANES+l)*2+1] & bad[(c*LANES+l)*2+1]
                   & (good[(c*LANES+l)*2] ^ bad[(c*LANES+l)*2]);
      end
      w_panic[c]   = |w_gu[c];
      w_error[c]   = !w_panic[c] && (|w_bu[c]);
      w_wrong[c]   = !w_panic[c] && !w_error[c] && (|w_df[c]);
      w_correct[c] = !(w_panic[c] || w_error[c] || w_wrong[c]);
      w_n_corr     = w_n_corr  + {4'b0, w_correct[c]};
      w_n_wrong    = w_n_wrong + {4'b0, w_wrong[c]};
      w_n_panic    = w_n_panic + {4'b0, w_panic[c]};
      w_n_err      = w_n_err   + {4'b0, w_error[c]};
    end
    // Scan downward so the lowest channel and lowest lane are the last to be written.
    for (int c = NCH - 1; c >= 0; c--) begin
      if (w_error[c] || w_wrong[c]) begin
        w_ev_found = 1'b1;
        w_ev_ch    = 4'(c);
        w_ev_lane  = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
          if (w_error[c] ? w_bu[c][l] : w_df[c][l]) w_ev_lane = 6'(l);
        end
      end
    end
  end

  assign w_sample = (r_state == StRun) && valid && !clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_cycles      <= '0;
      r_corrects    <= '0;
      r_wrongs      <= '0;
      r_panics      <= '0;
      r_errors      <= '0;
      r_first_valid <= 1'b0;
      r_first_cycle <= '0;
      r_first_ch    <= '0;
      r_first_lane  <= '0;
    end else begin
      if (clear) begin
        r_cycles      <= '0;
        r_corrects    <= '0;
        r_wrongs      <= '0;
        r_panics      <= '0;
        r_errors      <= '0;
        r_first_valid <= 1'b0;
        r_first_cycle <= '0;
        r_first_ch    <= '0;
        r_first_lane  <= '0;
      end else begin
        if (r_state == StRun) r_cycles <= sat_add(r_cycles, 5'd1);
        if (w_sample) begin
          r_corrects <= sat_add(r_corrects, w_n_corr);
          r_wrongs   <= sat_add(r_wrongs, w_n_wrong);
          r_panics   <= sat_add(r_panics, w_n_panic);
          r_errors   <= sat_add(r_errors, w_n_err);
          if (w_ev_found && !r_first_valid) begin
            r_first_valid <= 1'b1;
            r_first_cycle <= r_cycles;
            r_first_ch    <= w_ev_ch;
            r_first_lane  <= w_ev_lane;
          end
        end
      end
      case (r_state)
        StIdle: if (start && !stop) r_state <= StRun;
        StRun: begin
          if (stop) r_state <= StIdle;
          else if ((STOP_ON_WRONG != 0) && w_sample && w_ev_found) r_state <= StHalt;
        end
        StHalt: begin
          if (clear || stop) r_state <= StIdle;
          else if (start) r_state <= StRun;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign state       = r_state;
  assign cycles      = r_cycles;
  assign corrects    = r_corrects;
  assign wrongs      = r_wrongs;
  assign panics      = r_panics;
  assign errors      = r_errors;
  assign first_valid = r_first_valid;
  assign first_cycle = r_first_cycle;
  assign first_ch    = r_first_ch;
  assign first_lane  = r_first_lane;

endmodule

// File: tb/tb_color_scoreboard.sv
// Directed bench: one default instance, one halting instance and one 4-bit-counter
// instance share the stimulus; expectations are hand-computed.
module tb_color_scoreboard;

  localparam int NCH   = 4;
  localparam int LANES = 32;
  localparam int W     = NCH * 2 * LANES;

  logic clk = 1'b0;
  logic rst, start, stop, clear, valid;
  logic [W-1:0] good, bad;

  logic [1:0]  st0, st1, st2;
  logic [31:0] cyc0, cor0, wr0, pa0, er0, fcy0;
  logic [31:0] cyc1, cor1, wr1, pa1, er1, fcy1;
  logic [3:0]  cyc2, cor2, wr2, pa2, er2, fcy2;
  logic        fv0, fv1, fv2;
  logic [3:0]  fch0, fch1, fch2;
  logic [5:0]  fl0, fl1, fl2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  color_scoreboard #(.NCH(NCH), .LANES(LANES), .CNTW(32), .STOP_ON_WRONG(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .valid(valid),
    .good(good), .bad(bad), .state(st0), .cycles(cyc0), .corrects(cor0), .wrongs(wr0),
    .panics(pa0), .errors(er0), .first_valid(fv0), .first_cycle(fcy0), .first_ch(fch0),
    .first_lane(fl0)
  );

  color_scoreboard #(.NCH(NCH), .LANES(LANES), .CNTW(32), .STOP_ON_WRONG(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .valid(valid),
    .good(good), .bad(bad), .state(st1), .cycles(cyc1), .corrects(cor1), .wrongs(wr1),
    .panics(pa1), .errors(er1), .first_valid(fv1), .first_cycle(fcy1), .first_ch(fch1),
    .first_lane(fl1)
  );

  color_scoreboard #(.NCH(NCH), .LANES(LANES), .CNTW(4), .STOP_ON_WRONG(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .valid(valid),
    .good(good), .bad(bad), .state(st2), .cycles(cyc2), .corrects(cor2), .wrongs(wr2),
    .panics(pa2), .errors(er2), .first_valid(fv2), .first_cycle(fcy2), .first_ch(fch2),
    .first_lane(fl2)
  );

  typedef struct {
    logic start, stop, clear, valid;
    int   pat;
    int   st, corr, wrong, panic, err, cyc, fv, fcyc, fch, flane, corr4;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic s, sp, cl, v, input int p, est, c, w, pn, e,
                              cy, f, fc, fh, fl, c4);
    vec_t r;
    r.start = s; r.stop = sp; r.clear = cl; r.valid = v; r.pat = p;
    r.st = est; r.corr = c; r.wrong = w; r.panic = pn; r.err = e; r.cyc = cy;
    r.fv = f; r.fcyc = fc; r.fch = fh; r.flane = fl; r.corr4 = c4;
    return r;
  endfunction

  task automatic set_lane(inout logic [W-1:0] v, input int ch, input int ln,
                          input logic [1:0] val);
    v[(ch*LANES+ln)*2 +: 2] = val;
  endtask

  // 0 all-correct, 1 wrong ch2/lane5, 2 panic ch0 + error ch1, 3 panic ch1 + error ch3
  task automatic mkpat(input int p);
    logic [W-1:0] g, b;
    g = {(NCH*LANES){2'b10}};
    b = g;
    if (p == 1) set_lane(g, 2, 5, 2'b11);
    if (p == 2) begin
      set_lane(g, 0, 3, 2'b00);
      set_lane(b, 0, 3, 2'b01);
      set_lane(b, 1, 7, 2'b00);
    end
    if (p == 3) begin
      set_lane(g, 1, 0, 2'b00);
      set_lane(g, 3, 2, 2'b11);
      set_lane(b, 3, 4, 2'b00);
      set_lane(b, 3, 9, 2'b01);
    end
    good = g;
    bad  = b;
  endtask

  task automatic drive(input logic s, sp, cl, v, input int p);
    start = s; stop = sp; clear = cl; valid = v;
    mkpat(p);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    tbl[0] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++)
      tbl[k+1] = mk(0, 0, 0, 1, 0, 1, 4*k, 0, 0, 0, k, 0, 0, 0, 0, (4*k > 15) ? 15 : 4*k);
    tbl[12] = mk(0, 0, 0, 1, 1, 1, 43, 1, 0, 0, 11, 1, 10, 2, 5, 15);
    tbl[13] = mk(0, 0, 0, 1, 2, 1, 45, 1, 1, 1, 12, 1, 10, 2, 5, 15);
    tbl[14] = mk(0, 0, 0, 0, 1, 1, 45, 1, 1, 1, 13, 1, 10, 2, 5, 15);
    tbl[15] = mk(0, 1, 0, 1, 0, 0, 49, 1, 1, 1, 14, 1, 10, 2, 5, 15);
    tbl[16] = mk(1, 1, 0, 1, 0, 0, 49, 1, 1, 1, 14, 1, 10, 2, 5, 15);
    tbl[17] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset overrides start/valid.
    rst = 1'b1;
    drive(1, 0, 0, 1, 0);
    step();
    step();
    chk("rst_state", st0, 0);
    chk("rst_corrects", cor0, 0);
    chk("rst_cycles", cyc0, 0);
    chk("rst_first_valid", fv0, 0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].clear, tbl[i].valid, tbl[i].pat);
      step();
      chk($sformatf("row%0d_state", i), st0, tbl[i].st);
      chk($sformatf("row%0d_corrects", i), cor0, tbl[i].corr);
      chk($sformatf("row%0d_wrongs", i), wr0, tbl[i].wrong);
      chk($sformatf("row%0d_panics", i), pa0, tbl[i].panic);
      chk($sformatf("row%0d_errors", i), er0, tbl[i].err);
      chk($sformatf("row%0d_cycles", i), cyc0, tbl[i].cyc);
      chk($sformatf("row%0d_first_valid", i), fv0, tbl[i].fv);
      chk($sformatf("row%0d_first_cycle", i), fcy0, tbl[i].fcyc);
      chk($sformatf("row%0d_first_ch", i), fch0, tbl[i].fch);
      chk($sformatf("row%0d_first_lane", i), fl0, tbl[i].flane);
      chk($sformatf("row%0d_sat_corrects", i), cor2, tbl[i].corr4);
    end

    // Halt on first wrong: counted, then frozen until clear.
    drive(1, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 1, 0);
      step();
    end
    chk("halt_pre_cycles", cyc1, 7);
    drive(0, 0, 0, 1, 1);
    step();
    chk("halt_state", st1, 2);
    chk("halt_wrongs", wr1, 1);
    chk("halt_corrects", cor1, 31);
    chk("halt_cycles", cyc1, 8);
    chk("halt_first_cycle", fcy1, 7);
    chk("halt_first_valid", fv1, 1);
    drive(0, 0, 0, 1, 1);
    step();
    chk("halt_frozen_wrongs", wr1, 1);
    chk("halt_frozen_corrects", cor1, 31);
    chk("halt_frozen_cycles", cyc1, 8);
    drive(0, 0, 1, 0, 0);
    step();
    chk("halt_clear_state", st1, 0);
    chk("halt_clear_corrects", cor1, 0);
    chk("halt_clear_wrongs", wr1, 0);
    chk("halt_clear_cycles", cyc1, 0);
    chk("halt_clear_first_valid", fv1, 0);
    chk("halt_clear_first_cycle", fcy1, 0);
    chk("run_clear_state", st0, 1);
    chk("run_clear_corrects", cor0, 0);

    // Error channel capture picks lowest uncolored bad lane; panic channel is skipped.
    drive(0, 1, 0, 0, 0);
    step();
    chk("stop_state", st0, 0);
    drive(1, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 3);
    step();
    chk("err_panics", pa0, 1);
    chk("err_errors", er0, 1);
    chk("err_corrects", cor0, 2);
    chk("err_wrongs", wr0, 0);
    chk("err_first_valid", fv0, 1);
    chk("err_first_ch", fch0, 3);
    chk("err_first_lane", fl0, 4);
    chk("err_first_cycle", fcy0, 1);

    // Reset mid-run with a valid wrong sample and start asserted.
    rst = 1'b1;
    drive(1, 0, 0, 1, 1);
    step();
    chk("midrst_state", st0, 0);
    chk("midrst_corrects", cor0, 0);
    chk("midrst_panics", pa0, 0);
    chk("midrst_errors", er0, 0);
    chk("midrst_wrongs", wr0, 0);
    chk("midrst_cycles", cyc0, 0);
    chk("midrst_first_valid", fv0, 0);
    chk("midrst_first_ch", fch0, 0);
    chk("midrst_first_lane", fl0, 0);
    chk("midrst_state_halting", st1, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
